serial_xs3_codec: RTL

- Bit-serial, LSB-first, multi-digit BCD/Excess-3 codec.
- Mode 0 encodes BCD to Excess-3 (digit + 3). Mode 1 decodes Excess-3 to BCD (digit − 3).
- Processes framed words of DIGITS nibbles, one bit per accepted cycle, and flags out-of-range digits.
- Replaces the single-digit fixed-function serial converter in the serial-arithmetic datapath.

---
 rtl/serial_xs3_codec.sv | 89 ++++++++
 1 files changed

// File: rtl/serial_xs3_codec.sv
// serial_xs3_codec: bit-serial LSB-first multi-digit BCD<->Excess-3 codec with range flags.
module serial_xs3_codec #(
   parameter int DIGITS = 4,
   parameter int CW     = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mode,
   input  logic          in_valid,
   input  logic          in_start,
   input  logic          x,
   output logic          out_valid,
   output logic          s,
   output logic          digit_end,
   output logic          v,
   output logic          err,
   output logic          word_end,
   output logic          busy,
   output logic [CW-1:0] digit_idx
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_n;
   logic mode_q, c, tail, start, acc, em, k, ec, s_n, c_n, err_n, last;
   logic [1:0] bit_cnt, eb;
   logic [2:0] sh;
   logic [3:0] nib;
   logic [CW-1:0] ed;
   always_ff @(negedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   // A start bit landing on the final bit of a word completes that word instead of restarting.
   assign tail  = (state == ACTIVE) && (bit_cnt == 2'd3) && (digit_idx == CW'(DIGITS - 1));
   assign start = in_valid & in_start & ~tail;
   assign acc   = start | (in_valid & (state == ACTIVE));
   assign eb    = start ? 2'd0 : bit_cnt;
   assign ed    = start ? '0 : (bit_cnt == 2'd0 ? digit_idx + CW'(1) : digit_idx);
   assign last  = ed == CW'(DIGITS - 1);
   always_comb begin
      state_n = start ? ACTIVE : (acc && eb == 2'd3 && last) ? IDLE : state;
   end
   always_comb begin
      em    = start ? mode : mode_q;
      k     = ~eb[1];
      ec    = (eb == 2'd0) ? 1'b0 : c;
      s_n   = x ^ k ^ ec;
      c_n   = em ? ((~x & (k | ec)) | (k & ec)) : ((x & k) | (x & ec) | (k & ec));
      nib   = {x, sh};
      err_n = em ? (nib < 4'd3 || nib > 4'd12) : (nib > 4'd9);
   end
   always_ff @(negedge clk) begin
      if (reset) begin
         mode_q    <= 1'b0;
         c         <= 1'b0;
         bit_cnt   <= 2'd0;
         sh        <= 3'd0;
         digit_idx <= '0;
         out_valid <= 1'b0;
         s         <= 1'b0;
         digit_end <= 1'b0;
         v         <= 1'b0;
         err       <= 1'b0;
         word_end  <= 1'b0;
         busy      <= 1'b0;
      end else if (acc) begin
         mode_q    <= em;
         c         <= c_n;
         bit_cnt   <= eb + 2'd1;
         sh        <= {x, sh[2:1]};
         digit_idx <= ed;
         out_valid <= 1'b1;
         s         <= s_n;
         digit_end <= eb == 2'd3;
         v         <= (eb == 2'd3) & c_n;
         err       <= (eb == 2'd3) & err_n;
         word_end  <= (eb == 2'd3) & last;
         busy      <= 1'b1;
      end else begin
         digit_idx <= (state == IDLE) ? '0 : digit_idx;
         out_valid <= 1'b0;
         s         <= 1'b0;
         digit_end <= 1'b0;
         v         <= 1'b0;
         err       <= 1'b0;
         word_end  <= 1'b0;
         busy      <= state == ACTIVE;
      end
   end
endmodule
